pid_calc: RTL and testbench

- Downstream of cal_error. Consumes the P/I/D error triplets for pitch, roll and yaw.
- Computes one PID control output per axis: out = (Kp·e + Ki·i + Kd·d) >> FRAC, then saturates to OUT_W.
- Uses a single time-multiplexed signed multiplier-accumulator, sequenced by an FSM with a start/busy/done handshake.
- Results feed the motor mixer.

---
 rtl/pid_calc.sv | 174 +++++++++++++++++
 tb/tb_pid_calc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pid_calc.sv
// Three-axis PID calculator built around one time-multiplexed signed MAC.
// A start latches all errors and gains. Each axis then takes three MAC
// edges (P, I, D) and one WRITE edge. A final publish edge updates all
// three outputs together and pulses pid_done.
module pid_calc #(
  parameter int unsigned ERR_W  = 24,
  parameter int unsigned GAIN_W = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pid_en,
  input  logic [ERR_W-1:0]  pitch_error,
  input  logic [ERR_W-1:0]  roll_error,
  input  logic [ERR_W-1:0]  yaw_error,
  input  logic [ERR_W-1:0]  i_pitch_error,
  input  logic [ERR_W-1:0]  i_roll_error,
  input  logic [ERR_W-1:0]  i_yaw_error,
  input  logic [ERR_W-1:0]  d_pitch_error,
  input  logic [ERR_W-1:0]  d_roll_error,
  input  logic [ERR_W-1:0]  d_yaw_error,
  input  logic [GAIN_W-1:0] kp_pr,
  input  logic [GAIN_W-1:0] ki_pr,
  input  logic [GAIN_W-1:0] kd_pr,
  input  logic [GAIN_W-1:0] kp_y,
  input  logic [GAIN_W-1:0] ki_y,
  input  logic [GAIN_W-1:0] kd_y,
  output logic [OUT_W-1:0]  pitch_out,
  output logic [OUT_W-1:0]  roll_out,
  output logic [OUT_W-1:0]  yaw_out,
  output logic              pid_busy,
  output logic              pid_done
);

  localparam int unsigned PROD_W = ERR_W + GAIN_W;
  localparam int unsigned ACC_W  = ERR_W + GAIN_W + 2;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(OUT_MIN);

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                axis_q, axis_d;   // 0 pitch, 1 roll, 2 yaw, 3 publish
  logic [1:0]                term_q, term_d;   // 0 P, 1 I, 2 D
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ERR_W-1:0]   err_q [9];        // {P,I,D} x {pitch,roll,yaw}
  logic signed [ERR_W-1:0]   err_d [9];
  logic signed [GAIN_W-1:0]  gain_q [6];       // {kp,ki,kd} pitch/roll, then yaw
  logic signed [GAIN_W-1:0]  gain_d [6];
  logic signed [OUT_W-1:0]   res_q [3];
  logic signed [OUT_W-1:0]   res_d [3];
  logic signed [OUT_W-1:0]   out_q [3];
  logic signed [OUT_W-1:0]   out_d [3];
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [3:0]                err_idx;
  logic [2:0]                gain_idx;
  logic signed [ERR_W-1:0]   err_sel;
  logic signed [GAIN_W-1:0]  gain_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [OUT_W-1:0]   sat;

  // Operand select and product for the current axis/term.
  always_comb begin
    err_idx  = 4'(axis_q) * 4'd3 + 4'(term_q);
    gain_idx = ((axis_q == 2'd2) ? 3'd3 : 3'd0) + 3'(term_q);
    err_sel  = err_q[err_idx];
    gain_sel = gain_q[gain_idx];
    prod     = PROD_W'(err_sel) * PROD_W'(gain_sel);
  end

  // Floor scaling by FRAC then clamp into the output range.
  always_comb begin
    shifted = acc_q >>> FRAC;
    if (shifted > SAT_MAX)      sat = OUT_MAX;
    else if (shifted < SAT_MIN) sat = OUT_MIN;
    else                        sat = OUT_W'(shifted);
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    axis_d  = axis_q;
    term_d  = term_q;
    acc_d   = acc_q;
    err_d   = err_q;
    gain_d  = gain_q;
    res_d   = res_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pid_en) begin
          err_d[0] = pitch_error;  err_d[1] = i_pitch_error; err_d[2] = d_pitch_error;
          err_d[3] = roll_error;   err_d[4] = i_roll_error;  err_d[5] = d_roll_error;
          err_d[6] = yaw_error;    err_d[7] = i_yaw_error;   err_d[8] = d_yaw_error;
          gain_d[0] = kp_pr; gain_d[1] = ki_pr; gain_d[2] = kd_pr;
          gain_d[3] = kp_y;  gain_d[4] = ki_y;  gain_d[5] = kd_y;
          acc_d   = '0;
          axis_d  = 2'd0;
          term_d  = 2'd0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (term_q == 2'd2) begin
          term_d  = 2'd0;
          state_d = WRITE;
        end else begin
          term_d = term_q + 2'd1;
        end
      end
      WRITE: begin
        if (axis_q == 2'd3) begin
          out_d   = res_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          axis_d  = 2'd0;
          state_d = IDLE;
        end else begin
          res_d[axis_q] = sat;
          acc_d         = '0;
          axis_d        = axis_q + 2'd1;
          if (axis_q != 2'd2) state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      axis_q  <= 2'd0;
      term_q  <= 2'd0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 9; k++) err_q[k] <= '0;
      for (int k = 0; k < 6; k++) gain_q[k] <= '0;
      for (int k = 0; k < 3; k++) begin
        res_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gain_q  <= gain_d;
      res_q   <= res_d;
      out_q   <= out_d;
    end
  end

  assign pitch_out = out_q[0];
  assign roll_out  = out_q[1];
  assign yaw_out   = out_q[2];
  assign pid_busy  = busy_q;
  assign pid_done  = done_q;

endmodule

// File: tb/tb_pid_calc.sv
// Self-checking bench for pid_calc: directed vector table, hand-written
// busy/restart and reset-abort sequences, and random vectors checked
// against an arithmetic PID model.
module tb_pid_calc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pid_en = 1'b0;
  logic [23:0] pitch_error = '0, roll_error = '0, yaw_error = '0;
  logic [23:0] i_pitch_error = '0, i_roll_error = '0, i_yaw_error = '0;
  logic [23:0] d_pitch_error = '0, d_roll_error = '0, d_yaw_error = '0;
  logic [15:0] kp_pr = '0, ki_pr = '0, kd_pr = '0, kp_y = '0, ki_y = '0, kd_y = '0;
  logic [15:0] pitch_out, roll_out, yaw_out;
  logic        pid_busy, pid_done;

  int checks = 0;
  int errors = 0;

  pid_calc dut (
    .clk(clk), .rst_n(rst_n), .pid_en(pid_en),
    .pitch_error(pitch_error), .roll_error(roll_error), .yaw_error(yaw_error),
    .i_pitch_error(i_pitch_error), .i_roll_error(i_roll_error), .i_yaw_error(i_yaw_error),
    .d_pitch_error(d_pitch_error), .d_roll_error(d_roll_error), .d_yaw_error(d_yaw_error),
    .kp_pr(kp_pr), .ki_pr(ki_pr), .kd_pr(kd_pr),
    .kp_y(kp_y), .ki_y(ki_y), .kd_y(kd_y),
    .pitch_out(pitch_out), .roll_out(roll_out), .yaw_out(yaw_out),
    .pid_busy(pid_busy), .pid_done(pid_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] pe, pi, pd, re, ri, rd, ye, yi, yd;
    logic [15:0] kp, ki, kd, kpy, kiy, kdy;
    int          ep, er, ey;
  } vec_t;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: full-precision sum, floor divide by 2^8, clamp to 16 bits.
  function automatic int model_axis(input logic [23:0] e, i, d,
                                    input logic [15:0] kp, ki, kd);
    longint s;
    s = longint'($signed(e)) * longint'($signed(kp))
      + longint'($signed(i)) * longint'($signed(ki))
      + longint'($signed(d)) * longint'($signed(kd));
    s = s >>> 8;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic apply(input vec_t v);
    pitch_error = v.pe; i_pitch_error = v.pi; d_pitch_error = v.pd;
    roll_error  = v.re; i_roll_error  = v.ri; d_roll_error  = v.rd;
    yaw_error   = v.ye; i_yaw_error   = v.yi; d_yaw_error   = v.yd;
    kp_pr = v.kp;  ki_pr = v.ki;  kd_pr = v.kd;
    kp_y  = v.kpy; ki_y  = v.kiy; kd_y  = v.kdy;
  endtask

  task automatic check_outs(input string nm, input int ep, input int er, input int ey);
    check({nm, " pitch"}, longint'($signed(pitch_out)), longint'(ep));
    check({nm, " roll"},  longint'($signed(roll_out)),  longint'(er));
    check({nm, " yaw"},   longint'($signed(yaw_out)),   longint'(ey));
  endtask

  // Pulse pid_en for one sampling edge (E0), then wait for pid_done.
  task automatic run(input string nm, input int ep, input int er, input int ey);
    int lat;
    logic [15:0] p0, r0, y0;
    bit bad_busy, bad_hold;
    p0 = pitch_out; r0 = roll_out; y0 = yaw_out;
    bad_busy = 0; bad_hold = 0;
    @(negedge clk); pid_en = 1'b1;
    @(posedge clk); #1; pid_en = 1'b0;
    check({nm, " busy after start"}, longint'(pid_busy), 1);
    lat = 0;
    while (!pid_done && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (!pid_done) begin
        if (pid_busy !== 1'b1) bad_busy = 1;
        if (pitch_out !== p0 || roll_out !== r0 || yaw_out !== y0) bad_hold = 1;
      end
    end
    check({nm, " latency"}, longint'(lat), 13);
    check({nm, " busy held"}, longint'(bad_busy), 0);
    check({nm, " outputs held mid-run"}, longint'(bad_hold), 0);
    check({nm, " busy at done"}, longint'(pid_busy), 0);
    check_outs(nm, ep, er, ey);
    @(posedge clk); #1;
    check({nm, " done width"}, longint'(pid_done), 0);
  endtask

  vec_t tbl [8];
  vec_t v;

  initial begin
    tbl[0] = '{"basic_p", 24'd100, 0, 0, 0, 0, 0, 0, 0, 0,
               16'd256, 0, 0, 0, 0, 0, 100, 0, 0};
    tbl[1] = '{"full_pid", 24'd100, 24'd150, -24'sd50, 24'd100, 24'd150, -24'sd50, 0, 0, 0,
               16'd512, 16'd128, 16'hFF00, 0, 0, 0, 325, 325, 0};
    tbl[2] = '{"yaw_floor_neg", 0, 0, 0, 0, 0, 0, -24'sd3, 0, 0,
               0, 0, 0, 16'd128, 0, 0, 0, 0, -2};
    tbl[3] = '{"yaw_floor_pos", 0, 0, 0, 0, 0, 0, 24'd3, 0, 0,
               0, 0, 0, 16'd128, 0, 0, 0, 0, 1};
    tbl[4] = '{"sat_pos", 24'h7FFFFF, 0, 0, 0, 24'h7FFFFF, 0, 0, 0, 0,
               16'd256, 16'h7FFF, 0, 0, 0, 0, 32767, 32767, 0};
    tbl[5] = '{"sat_neg", 24'h800000, 0, 0, 0, 0, 0, 0, 0, 0,
               16'd256, 0, 0, 0, 0, 0, -32768, 0, 0};
    tbl[6] = '{"neg_gain_yaw", 0, 0, 0, 0, 0, 0, 24'd1000, -24'sd20, 0,
               0, 0, 0, 16'hFF00, 16'd128, 0, 0, 0, -1010};
    tbl[7] = '{"zero_gains", 24'd55, 24'd66, 24'd77, 24'd88, 24'd99, 24'd11, 24'd22, 24'd33, 24'd44,
               0, 0, 0, 0, 0, 0, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0);
    check("reset busy", longint'(pid_busy), 0);
    check("reset done", longint'(pid_done), 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[k]) begin
      apply(tbl[k]);
      run(tbl[k].name, tbl[k].ep, tbl[k].er, tbl[k].ey);
    end

    // Busy ignore, input latching and earliest restart at E14.
    begin
      int dones;
      v = tbl[0];
      apply(v);
      @(negedge clk); pid_en = 1'b1;
      @(posedge clk); #1; pid_en = 1'b0;
      dones = 0;
      for (int c = 1; c <= 13; c++) begin
        @(posedge clk); #1;
        if (pid_done) dones++;
        if (c == 4) begin pitch_error = 24'd999; pid_en = 1'b1; end
        if (c == 5) pid_en = 1'b0;
        if (c == 13) begin
          check("busy_ignore done at E13", longint'(pid_done), 1);
          check("busy_ignore pitch", longint'($signed(pitch_out)), 100);
          pid_en = 1'b1;
        end
      end
      @(posedge clk); #1; pid_en = 1'b0;
      if (pid_done) dones++;
      check("busy_ignore single done", longint'(dones), 1);
      check("restart busy at E14", longint'(pid_busy), 1);
      dones = 0;
      for (int c = 1; c <= 13; c++) begin
        @(posedge clk); #1;
        if (pid_done) dones++;
      end
      check("restart done at 13", longint'(pid_done), 1);
      check("restart dones", longint'(dones), 1);
      check("restart pitch", longint'($signed(pitch_out)), 999);
    end

    // Reset mid-run aborts with no done pulse; a fresh run then completes.
    begin
      int dones;
      v = tbl[1];
      apply(v);
      @(negedge clk); pid_en = 1'b1;
      @(posedge clk); #1; pid_en = 1'b0;
      for (int c = 1; c <= 5; c++) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check_outs("mid_reset", 0, 0, 0);
      check("mid_reset busy", longint'(pid_busy), 0);
      @(negedge clk); rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (pid_done) dones++;
      end
      check("mid_reset no done", longint'(dones), 0);
      check_outs("mid_reset idle", 0, 0, 0);
      apply(tbl[0]);
      run("after_reset", 100, 0, 0);
    end

    // Random vectors against the arithmetic model.
    for (int n = 0; n < 30; n++) begin
      v.name = "random";
      v.pe = 24'($urandom); v.pi = 24'($urandom); v.pd = 24'($urandom);
      v.re = 24'($urandom); v.ri = 24'($urandom); v.rd = 24'($urandom);
      v.ye = 24'($urandom); v.yi = 24'($urandom); v.yd = 24'($urandom);
      if (n % 2 == 0) begin
        v.pe = 24'($signed(12'($urandom))); v.ri = 24'($signed(12'($urandom)));
        v.yd = 24'($signed(12'($urandom))); v.re = 24'($signed(10'($urandom)));
      end
      v.kp  = 16'($urandom); v.ki  = 16'($urandom); v.kd  = 16'($urandom);
      v.kpy = 16'($urandom); v.kiy = 16'($urandom); v.kdy = 16'($urandom);
      if (n % 3 == 0) begin
        v.kp  = 16'($signed(10'($urandom))); v.ki  = 16'($signed(10'($urandom)));
        v.kd  = 16'($signed(10'($urandom))); v.kpy = 16'($signed(10'($urandom)));
        v.kiy = 16'($signed(10'($urandom))); v.kdy = 16'($signed(10'($urandom)));
        v.pi = 24'($signed(14'($urandom))); v.pd = 24'($signed(14'($urandom)));
        v.rd = 24'($signed(14'($urandom))); v.ye = 24'($signed(14'($urandom)));
        v.yi = 24'($signed(14'($urandom)));
      end
      v.ep = model_axis(v.pe, v.pi, v.pd, v.kp, v.ki, v.kd);
      v.er = model_axis(v.re, v.ri, v.rd, v.kp, v.ki, v.kd);
      v.ey = model_axis(v.ye, v.yi, v.yd, v.kpy, v.kiy, v.kdy);
      apply(v);
      run("random", v.ep, v.er, v.ey);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
